// File: rtl/decode_stage.sv
// RV32I decode stage: valid/ready pipeline register, 32x32 register file, control decode.
// Optional macro WB_BYPASS_EN forwards same-cycle writeback data onto operand reads.
module decode_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [XLEN-1:0] if_pc,
    input  logic [31:0]     if_instr,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_rs1_val,
    output logic [XLEN-1:0] id_rs2_val,
    output logic [XLEN-1:0] id_imm,
    output logic [4:0]      id_rd,
    output logic [3:0]      id_alu_op,
    output logic            id_use_imm,
    output logic            id_reg_write,
    output logic            id_illegal
);

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
    } alu_op_e;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [4:0] rd, rs1, rs2;

    assign opcode = if_instr[6:0];
    assign rd     = if_instr[11:7];
    assign funct3 = if_instr[14:12];
    assign rs1    = if_instr[19:15];
    assign rs2    = if_instr[24:20];
    assign funct7 = if_instr[31:25];

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];

    logic            id_valid_q, id_valid_d;
    logic [XLEN-1:0] id_pc_q, id_pc_d;
    logic [XLEN-1:0] id_rs1_val_q, id_rs1_val_d;
    logic [XLEN-1:0] id_rs2_val_q, id_rs2_val_d;
    logic [XLEN-1:0] id_imm_q, id_imm_d;
    logic [4:0]      id_rd_q, id_rd_d;
    alu_op_e         id_alu_op_q, id_alu_op_d;
    logic            id_use_imm_q, id_use_imm_d;
    logic            id_reg_write_q, id_reg_write_d;
    logic            id_illegal_q, id_illegal_d;

    alu_op_e         dec_alu_op;
    logic [XLEN-1:0] dec_imm;
    logic            dec_use_imm, dec_legal, dec_nop;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic            xfer;

    always_comb begin
        dec_alu_op  = ALU_ADD;
        dec_imm     = '0;
        dec_use_imm = 1'b0;
        dec_legal   = 1'b0;
        dec_nop     = (if_instr == 32'h0);
        case (opcode)
            OPC_OP_IMM: begin
                dec_use_imm = 1'b1;
                dec_legal   = 1'b1;
                dec_imm     = XLEN'($signed(if_instr[31:20]));
                case (funct3)
                    3'b000: dec_alu_op = ALU_ADD;
                    3'b010: dec_alu_op = ALU_SLT;
                    3'b011: dec_alu_op = ALU_SLTU;
                    3'b100: dec_alu_op = ALU_XOR;
                    3'b110: dec_alu_op = ALU_OR;
                    3'b111: dec_alu_op = ALU_AND;
                    3'b001: begin
                        dec_alu_op = ALU_SLL;
                        dec_imm    = XLEN'(rs2);
                        dec_legal  = (funct7 == F7_ZERO);
                    end
                    default: begin
                        dec_alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
                        dec_imm    = XLEN'(rs2);
                        dec_legal  = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
                    end
                endcase
            end
            OPC_OP: begin
                if (funct7 == F7_ZERO) begin
                    dec_legal = 1'b1;
                    case (funct3)
                        3'b000:  dec_alu_op = ALU_ADD;
                        3'b001:  dec_alu_op = ALU_SLL;
                        3'b010:  dec_alu_op = ALU_SLT;
                        3'b011:  dec_alu_op = ALU_SLTU;
                        3'b100:  dec_alu_op = ALU_XOR;
                        3'b101:  dec_alu_op = ALU_SRL;
                        3'b110:  dec_alu_op = ALU_OR;
                        default: dec_alu_op = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    dec_legal  = 1'b1;
                    dec_alu_op = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    dec_legal  = 1'b1;
                    dec_alu_op = ALU_SRA;
                end
            end
            OPC_LUI: begin
                dec_legal   = 1'b1;
                dec_use_imm = 1'b1;
                dec_alu_op  = ALU_PASSB;
                dec_imm     = XLEN'($signed({if_instr[31:12], 12'h000}));
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // Reads see the pre-write register value unless same-cycle forwarding is built in.
    always_comb begin
        rs1_val = (rs1 == 5'd0) ? '0 : regs_q[rs1];
        rs2_val = (rs2 == 5'd0) ? '0 : regs_q[rs2];
`ifdef WB_BYPASS_EN
        if (wb_en && wb_rd == rs1 && rs1 != 5'd0) rs1_val = wb_data;
        if (wb_en && wb_rd == rs2 && rs2 != 5'd0) rs2_val = wb_data;
`else
`endif
    end

    always_comb begin
        regs_d = regs_q;
        if (wb_en && wb_rd != 5'd0) regs_d[wb_rd] = wb_data;
    end

    assign if_ready = !id_valid_q || id_ready;
    assign xfer     = if_valid && if_ready;

    always_comb begin
        id_valid_d     = id_valid_q;
        id_pc_d        = id_pc_q;
        id_rs1_val_d   = id_rs1_val_q;
        id_rs2_val_d   = id_rs2_val_q;
        id_imm_d       = id_imm_q;
        id_rd_d        = id_rd_q;
        id_alu_op_d    = id_alu_op_q;
        id_use_imm_d   = id_use_imm_q;
        id_reg_write_d = id_reg_write_q;
        id_illegal_d   = id_illegal_q;
        if (flush) begin
            id_valid_d = 1'b0;
        end else if (xfer) begin
            id_valid_d     = 1'b1;
            id_pc_d        = if_pc;
            id_rs1_val_d   = rs1_val;
            id_rs2_val_d   = rs2_val;
            id_imm_d       = dec_imm;
            id_rd_d        = rd;
            id_alu_op_d    = dec_alu_op;
            id_use_imm_d   = dec_use_imm;
            id_reg_write_d = dec_legal && (rd != 5'd0);
            id_illegal_d   = !dec_legal && !dec_nop;
        end else if (id_ready) begin
            id_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
            id_valid_q     <= 1'b0;
            id_pc_q        <= '0;
            id_rs1_val_q   <= '0;
            id_rs2_val_q   <= '0;
            id_imm_q       <= '0;
            id_rd_q        <= '0;
            id_alu_op_q    <= ALU_ADD;
            id_use_imm_q   <= 1'b0;
            id_reg_write_q <= 1'b0;
            id_illegal_q   <= 1'b0;
        end else begin
            regs_q         <= regs_d;
            id_valid_q     <= id_valid_d;
            id_pc_q        <= id_pc_d;
            id_rs1_val_q   <= id_rs1_val_d;
            id_rs2_val_q   <= id_rs2_val_d;
            id_imm_q       <= id_imm_d;
            id_rd_q        <= id_rd_d;
            id_alu_op_q    <= id_alu_op_d;
            id_use_imm_q   <= id_use_imm_d;
            id_reg_write_q <= id_reg_write_d;
            id_illegal_q   <= id_illegal_d;
        end
    end

    assign id_valid     = id_valid_q;
    assign id_pc        = id_pc_q;
    assign id_rs1_val   = id_rs1_val_q;
    assign id_rs2_val   = id_rs2_val_q;
    assign id_imm       = id_imm_q;
    assign id_rd        = id_rd_q;
    assign id_alu_op    = id_alu_op_q;
    assign id_use_imm   = id_use_imm_q;
    assign id_reg_write = id_reg_write_q;
    assign id_illegal   = id_illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a driver pushes expected decodes from an ISA-level model,
// a negedge monitor pops and compares on each handoff and checks stall stability.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid, if_ready, flush, wb_en, id_valid, id_ready;
    logic [31:0] if_pc, if_instr, wb_data;
    logic [4:0]  wb_rd;
    logic [31:0] id_pc, id_rs1_val, id_rs2_val, id_imm;
    logic [4:0]  id_rd;
    logic [3:0]  id_alu_op;
    logic        id_use_imm, id_reg_write, id_illegal;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .NREGS(32)) dut (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_ready(if_ready),
        .if_pc(if_pc), .if_instr(if_instr), .flush(flush), .wb_en(wb_en),
        .wb_rd(wb_rd), .wb_data(wb_data), .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm),
        .id_rd(id_rd), .id_alu_op(id_alu_op), .id_use_imm(id_use_imm),
        .id_reg_write(id_reg_write), .id_illegal(id_illegal)
    );

    typedef struct {
        logic [31:0] pc, rs1, rs2, imm;
        logic [4:0]  rd;
        logic [3:0]  alu;
        logic        use_imm, reg_write, illegal;
        bit          chk_rd, chk_alu, chk_use, chk_rs1, chk_rs2, chk_imm;
    } exp_t;

    exp_t        q[$];
    logic [31:0] model_rf [32];
    int          passed = 0;
    int          total  = 0;
    bit          mon_en = 1'b0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [159:0] outs();
        return {19'h0, id_pc, id_rs1_val, id_rs2_val, id_imm, id_rd, id_alu_op,
                id_use_imm, id_reg_write, id_illegal, id_valid};
    endfunction

    function automatic logic [31:0] rd_reg(input logic [4:0] r);
        if (r == 5'd0) return 32'h0;
`ifdef WB_BYPASS_EN
        if (wb_en && wb_rd == r) return wb_data;
`endif
        return model_rf[r];
    endfunction

    // ISA-level reference: ALU codes ADD0 SUB1 SLL2 SLT3 SLTU4 XOR5 SRL6 SRA7 OR8 AND9 PASSB10
    function automatic exp_t model(input logic [31:0] instr, input logic [31:0] pc);
        exp_t        e;
        int          f3_tab [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
        logic [6:0]  opc = instr[6:0];
        logic [6:0]  f7  = instr[31:25];
        int          f3  = int'(instr[14:12]);
        bit          legal = 1'b0;
        e = '{default: '0};
        e.pc = pc;
        e.rd = instr[11:7];
        e.rs1 = rd_reg(instr[19:15]);
        e.rs2 = rd_reg(instr[24:20]);
        if (instr == 32'h0) begin
            e.rd = 5'd0; e.alu = 4'd0; e.chk_rd = 1; e.chk_alu = 1;
            return e;
        end
        if (opc == 7'h13) begin
            e.use_imm = 1'b1; e.chk_rs1 = 1;
            if (f3 != 1 && f3 != 5) begin
                legal = 1'b1; e.alu = 4'(f3_tab[f3]);
                e.imm = {{20{instr[31]}}, instr[31:20]};
            end else begin
                e.imm = {27'h0, instr[24:20]};
                if (f7 == 7'h00) begin legal = 1'b1; e.alu = 4'(f3_tab[f3]); end
                else if (f7 == 7'h20 && f3 == 5) begin legal = 1'b1; e.alu = 4'd7; end
            end
            e.chk_imm = 1;
        end else if (opc == 7'h33) begin
            e.use_imm = 1'b0; e.chk_rs1 = 1; e.chk_rs2 = 1;
            if (f7 == 7'h00) begin legal = 1'b1; e.alu = 4'(f3_tab[f3]); end
            else if (f7 == 7'h20 && f3 == 0) begin legal = 1'b1; e.alu = 4'd1; end
            else if (f7 == 7'h20 && f3 == 5) begin legal = 1'b1; e.alu = 4'd7; end
        end else if (opc == 7'h37) begin
            legal = 1'b1; e.use_imm = 1'b1; e.alu = 4'd10; e.chk_imm = 1;
            e.imm = {instr[31:12], 12'h000};
        end
        if (legal) begin
            e.reg_write = (e.rd != 5'd0);
            e.chk_rd = 1; e.chk_alu = 1; e.chk_use = 1;
        end else begin
            e.illegal = 1'b1; e.chk_rs1 = 0; e.chk_rs2 = 0; e.chk_imm = 0;
        end
        return e;
    endfunction

    bit           stall_prev = 1'b0, flush_prev = 1'b0;
    logic [159:0] snap;

    always @(negedge clk) begin
        if (reset || !mon_en) begin
            stall_prev = 1'b0;
        end else begin
            check("id_valid", id_valid, q.size() != 0);
            check("if_ready", if_ready, (q.size() == 0) || id_ready);
            if (stall_prev && !flush_prev) check("stall_hold", outs(), snap);
            if (id_valid && id_ready && q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                check("pc", id_pc, e.pc);
                check("illegal", id_illegal, e.illegal);
                check("reg_write", id_reg_write, e.reg_write);
                if (e.chk_rd)  check("rd", id_rd, e.rd);
                if (e.chk_alu) check("alu_op", id_alu_op, e.alu);
                if (e.chk_use) check("use_imm", id_use_imm, e.use_imm);
                if (e.chk_rs1) check("rs1_val", id_rs1_val, e.rs1);
                if (e.chk_rs2) check("rs2_val", id_rs2_val, e.rs2);
                if (e.chk_imm) check("imm", id_imm, e.imm);
            end
            stall_prev = id_valid && !id_ready;
            flush_prev = flush;
            snap = outs();
        end
    end

    task automatic step(input bit v, input logic [31:0] pc, input logic [31:0] instr,
                        input bit rdy, input bit fl, input bit we,
                        input logic [4:0] wrd, input logic [31:0] wd, output bit xfer);
        @(posedge clk); #1;
        if_valid = v; if_pc = pc; if_instr = instr; id_ready = rdy;
        flush = fl; wb_en = we; wb_rd = wrd; wb_data = wd;
        @(negedge clk); #1;
        xfer = v && if_ready;
        if (fl) q.delete();
        else if (xfer) q.push_back(model(instr, pc));
        if (we && wrd != 5'd0) model_rf[wrd] = wd;
    endtask

    task automatic beat(input logic [31:0] pc, input logic [31:0] instr);
        bit x;
        step(1, pc, instr, 1, 0, 0, 5'd0, 32'h0, x);
    endtask

    task automatic idle(input bit rdy);
        bit x;
        step(0, 32'h0, 32'h0, rdy, 0, 0, 5'd0, 32'h0, x);
    endtask

    task automatic wb(input logic [4:0] r, input logic [31:0] d);
        bit x;
        step(0, 32'h0, 32'h0, 1, 0, 1, r, d, x);
    endtask

    function automatic logic [31:0] gen();
        logic [31:0] r   = $urandom();
        logic [4:0]  rd  = 5'($urandom());
        logic [4:0]  rs1 = 5'($urandom());
        logic [4:0]  rs2 = 5'($urandom());
        logic [2:0]  f3  = 3'($urandom());
        logic [6:0]  f7;
        case ($urandom_range(0, 9))
            0, 1: return {r[31:20], rs1, f3, rd, 7'h13};
            2:    return {(r[1] ? 7'h20 : 7'h00), rs2, rs1, (r[0] ? 3'd1 : 3'd5), rd, 7'h13};
            3, 4, 5: begin
                f7 = (r[2:1] == 2'b00) ? r[31:25] : (r[3] ? 7'h20 : 7'h00);
                return {f7, rs2, rs1, f3, rd, 7'h33};
            end
            6: return {r[31:12], rd, 7'h37};
            7: return r;
            8: return 32'h0;
            default: return {r[31:20], rs1, 3'd0, 5'd0, 7'h13};
        endcase
    endfunction

    initial begin
        bit x;
        int guard;
        logic [31:0] ins;
        reset = 1'b1; if_valid = 0; if_pc = 0; if_instr = 0; flush = 0;
        wb_en = 0; wb_rd = 0; wb_data = 0; id_ready = 1;
        for (int i = 0; i < 32; i++) model_rf[i] = 32'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_outputs", outs(), 160'h0);
        check("reset_if_ready", if_ready, 1'b1);
        #1 mon_en = 1'b1;

        beat(32'h100, 32'h00500113);                 // ADDI x2,x0,5
        idle(1);
        wb(5'd2, 32'd5);
        wb(5'd3, 32'd10);
        beat(32'h104, 32'h40310233);                 // SUB x4,x2,x3
        idle(1);
        wb(5'd0, 32'hDEADBEEF);
        beat(32'h108, 32'h000000B3);                 // ADD x1,x0,x0
        step(1, 32'h10C, 32'h000000B3, 1, 0, 1, 5'd0, 32'hDEADBEEF, x);
        idle(1);

        beat(32'h110, 32'h00310393);                 // ADDI x7,x2,3
        repeat (3) step(1, 32'h114, 32'h00310433, 0, 0, 0, 5'd0, 32'h0, x);
        step(1, 32'h114, 32'h00310433, 1, 0, 0, 5'd0, 32'h0, x);
        idle(1);

        step(1, 32'h118, 32'h00028313, 1, 0, 1, 5'd5, 32'h1234, x);  // ADDI x6,x5,0
        idle(1);

        beat(32'h11C, 32'hFFFFFFFF);
        beat(32'h120, 32'h00000000);
        beat(32'h124, 32'h123452B7);                 // LUI x5,0x12345
        idle(1);

        beat(32'h128, 32'h00310393);
        step(0, 32'h0, 32'h0, 0, 0, 0, 5'd0, 32'h0, x);
        step(1, 32'h12C, 32'h00310433, 0, 1, 0, 5'd0, 32'h0, x);
        step(1, 32'h130, 32'h00310433, 0, 1, 0, 5'd0, 32'h0, x);
        idle(0);
        idle(1);

        beat(32'h134, 32'h40310233);
        step(0, 32'h0, 32'h0, 0, 0, 0, 5'd0, 32'h0, x);
        @(posedge clk); #1;
        if_valid = 0; reset = 1'b1;
        q.delete();
        for (int i = 0; i < 32; i++) model_rf[i] = 32'h0;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("reset_mid_stall", outs(), 160'h0);
        beat(32'h138, 32'h40310233);
        idle(1);

        for (int n = 0; n < 400; n++) begin
            ins = gen();
            guard = 0;
            do begin
                step(1, 32'h1000 + 32'(n * 4), ins, $urandom_range(0, 3) != 0,
                     $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
                     5'($urandom()), $urandom(), x);
                guard++;
            end while (!x && guard < 100);
            check("accept_within_bound", x, 1'b1);
            if ($urandom_range(0, 7) == 0) idle($urandom_range(0, 1) == 1);
        end

        repeat (3) idle(1);
        check("scoreboard_empty", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
